uart_rx_cmd_ctrl: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/uart_rx_cmd_ctrl_if.sv | 25 ++
 rtl/uart_cmd_timer.sv | 29 ++
 rtl/uart_rx_cmd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_CMD     = 3'd1,
        GET_LEN     = 3'd2,
        GET_PAYLOAD = 3'd3,
        GET_CSUM    = 3'd4,
        HOLD        = 3'd5
    } cmd_state_t;

    typedef enum logic [1:0] {
        ERR_OVERRUN = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Command handshake and payload read port between the frame controller and its consumer.
interface uart_rx_cmd_ctrl_if #(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic          o_cmd_valid;
    logic          i_cmd_ready;
    logic [7:0]    o_cmd_id;
    logic [LW-1:0] o_cmd_len;
    logic [AW-1:0] i_pl_addr;
    logic [7:0]    o_pl_data;

    modport master (
        output o_cmd_valid, o_cmd_id, o_cmd_len, o_pl_data,
        input  i_cmd_ready, i_pl_addr
    );

    modport slave (
        input  o_cmd_valid, o_cmd_id, o_cmd_len, o_pl_data,
        output i_cmd_ready, i_pl_addr
    );

endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: saturates at TIMEOUT_CLKS-1, where it flags expiry.
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT_CLKS = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || clr) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    // A byte strobe in the expiry cycle wins over the timeout.
    assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Frames SYNC/CMD/LEN/payload/XOR-checksum packets from the UART receiver byte
// stream and holds validated commands for the core behind a valid/ready handshake.
module uart_rx_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned FPGA_clk_freq = 50000000,
    parameter int unsigned TIMEOUT_CLKS  = 500000,
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    uart_rx_cmd_ctrl_if.master cmd,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    if (TIMEOUT_CLKS < 2 || FPGA_clk_freq == 0) begin : g_param_check
        $error("uart_rx_cmd_ctrl: TIMEOUT_CLKS must be >= 2 and FPGA_clk_freq nonzero");
    end

    cmd_state_t    state_q, state_d;
    logic [7:0]    csum_q, csum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    cmd_id_q;
    logic [LW-1:0] cmd_len_q;
    logic          valid_q, busy_q, err_q;
    err_code_t     err_code_q, err_code_d;
    logic          err_d, id_we, len_we, buf_we;
    logic          timer_en, expired, last_pl;
    logic [7:0]    pl_buf [MAX_LEN];

    assign timer_en = (state_q != IDLE) && (state_q != HOLD);
    assign last_pl  = (LW'(idx_q) + LW'(1)) == cmd_len_q;

    uart_cmd_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (timer_en),
        .clr     (i_RX_DV),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: advance only on byte strobes, except timeout and HOLD exit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_RX_DV && i_RX_Byte == SYNC_BYTE) state_d = GET_CMD;
            end
            GET_CMD: begin
                if (i_RX_DV)      state_d = GET_LEN;
                else if (expired) state_d = IDLE;
            end
            GET_LEN: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte > MAX_LEN_B)   state_d = IDLE;
                    else if (i_RX_Byte == 8'd0)  state_d = GET_CSUM;
                    else                         state_d = GET_PAYLOAD;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            GET_PAYLOAD: begin
                if (i_RX_DV) begin
                    if (last_pl) state_d = GET_CSUM;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            GET_CSUM: begin
                if (i_RX_DV)      state_d = (i_RX_Byte == csum_q) ? HOLD : IDLE;
                else if (expired) state_d = IDLE;
            end
            HOLD: begin
                if (cmd.i_cmd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls and error decode
    always_comb begin
        err_d      = 1'b0;
        err_code_d = ERR_OVERRUN;
        csum_d     = csum_q;
        idx_d      = idx_q;
        id_we      = 1'b0;
        len_we     = 1'b0;
        buf_we     = 1'b0;
        if (expired) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
        case (state_q)
            IDLE: begin
                if (i_RX_DV && i_RX_Byte == SYNC_BYTE) csum_d = 8'd0;
            end
            GET_CMD: begin
                if (i_RX_DV) begin
                    id_we  = 1'b1;
                    csum_d = i_RX_Byte;
                end
            end
            GET_LEN: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte > MAX_LEN_B) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        len_we = 1'b1;
                        csum_d = csum_q ^ i_RX_Byte;
                        idx_d  = '0;
                    end
                end
            end
            GET_PAYLOAD: begin
                if (i_RX_DV) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ i_RX_Byte;
                    idx_d  = idx_q + AW'(1);
                end
            end
            GET_CSUM: begin
                if (i_RX_DV && i_RX_Byte != csum_q) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_CSUM;
                end
            end
            HOLD: begin
                if (i_RX_DV) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q     <= '0;
            idx_q      <= '0;
            cmd_id_q   <= '0;
            cmd_len_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_OVERRUN;
        end else begin
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            valid_q    <= (state_d == HOLD);
            busy_q     <= (state_d != IDLE);
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (id_we)  cmd_id_q  <= i_RX_Byte;
            if (len_we) cmd_len_q <= LW'(i_RX_Byte);
        end
    end

    // Payload storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (buf_we) pl_buf[idx_q] <= i_RX_Byte;
    end

    assign cmd.o_cmd_valid = valid_q;
    assign cmd.o_cmd_id    = cmd_id_q;
    assign cmd.o_cmd_len   = cmd_len_q;
    assign cmd.o_pl_data   = pl_buf[cmd.i_pl_addr];
    assign o_err           = err_q;
    assign o_err_code      = err_code_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frames plus randomized byte streams, checked
// every cycle against a frame-level reference model.
module tb_uart_rx_cmd_ctrl;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TOUT    = 100;
    localparam int unsigned AW      = $clog2(MAX_LEN);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_cmd_ctrl_if #(.MAX_LEN(MAX_LEN)) cmd_bus ();

    uart_rx_cmd_ctrl #(
        .FPGA_clk_freq (50000000),
        .TIMEOUT_CLKS  (TOUT),
        .MAX_LEN       (MAX_LEN),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_RX_DV    (rx_dv),
        .i_RX_Byte  (rx_byte),
        .cmd        (cmd_bus),
        .o_err      (err),
        .o_err_code (err_code),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: a frame is the byte list collected after a sync byte.
    bit           m_in_frame = 0;
    bit           m_holding  = 0;
    byte unsigned m_frm[$];
    int           m_silence  = 0;
    bit           m_err;
    int           m_code;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input byte unsigned b);
        int n;
        byte unsigned x;
        m_frm.push_back(b);
        n = m_frm.size();
        if (n == 2 && int'(b) > int'(MAX_LEN)) begin
            m_err = 1; m_code = 1; m_in_frame = 0;
        end else if (n >= 3 && n == int'(m_frm[1]) + 3) begin
            x = 0;
            for (int i = 0; i < n - 1; i++) x ^= m_frm[i];
            if (x == b) m_holding = 1;
            else begin m_err = 1; m_code = 2; end
            m_in_frame = 0;
        end
    endtask

    task automatic model_edge(input bit dv, input byte unsigned b, input bit rdy);
        m_err = 0; m_code = 0;
        if (m_holding) begin
            if (rdy) m_holding = 0;
            if (dv) begin m_err = 1; m_code = 0; end
        end else if (m_in_frame) begin
            if (dv) begin
                m_silence = 0;
                model_accept(b);
            end else begin
                m_silence++;
                if (m_silence >= int'(TOUT)) begin
                    m_err = 1; m_code = 3; m_in_frame = 0;
                end
            end
        end else if (dv && b == 8'hA5) begin
            m_in_frame = 1;
            m_silence  = 0;
            m_frm.delete();
        end
    endtask

    // One clock: drive inputs, let the edge pass, then compare outputs to the model.
    task automatic step(input bit dv, input byte unsigned b, input bit rdy);
        int len, a;
        rx_dv   = dv;
        rx_byte = dv ? b : 8'($urandom_range(0, 255));
        cmd_bus.i_cmd_ready = rdy;
        @(posedge clk);
        #1;
        model_edge(dv, b, rdy);
        rx_dv = 1'b0;
        cmd_bus.i_cmd_ready = 1'b0;
        check_eq("err", 32'(err), 32'(m_err));
        if (m_err) check_eq("err_code", 32'(err_code), 32'(m_code));
        check_eq("valid", 32'(cmd_bus.o_cmd_valid), 32'(m_holding));
        check_eq("busy", 32'(busy), 32'(m_in_frame | m_holding));
        if (m_holding) begin
            len = int'(m_frm[1]);
            check_eq("cmd_id", 32'(cmd_bus.o_cmd_id), 32'(m_frm[0]));
            check_eq("cmd_len", 32'(cmd_bus.o_cmd_len), 32'(len));
            if (len > 0) begin
                a = $urandom_range(0, len - 1);
                cmd_bus.i_pl_addr = AW'(a);
                #1;
                check_eq("pl_data", 32'(cmd_bus.o_pl_data), 32'(m_frm[2 + a]));
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'd0, rdy);
    endtask

    task automatic send(input byte unsigned q[$], input bit rdy);
        foreach (q[i]) step(1, q[i], rdy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(cmd_bus.o_cmd_valid), 32'd0);
        check_eq({tag, "_id"}, 32'(cmd_bus.o_cmd_id), 32'd0);
        check_eq({tag, "_len"}, 32'(cmd_bus.o_cmd_len), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_code"}, 32'(err_code), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        byte unsigned q[$];
        byte unsigned x;
        int len;

        cmd_bus.i_cmd_ready = 1'b0;
        cmd_bus.i_pl_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame with ready held high: valid lasts exactly one cycle
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        send(q, 1);
        idle(2, 1);

        // Garbage prefix, then a second sync byte taken as CMD with LEN=5
        q = '{8'h33, 8'hA5, 8'hA5, 8'h05, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'hA5};
        send(q, 0);
        idle(3, 0);
        idle(1, 1);

        // Zero-length frame
        q = '{8'hA5, 8'h05, 8'h00, 8'h05};
        send(q, 0);
        idle(1, 1);

        // Bad checksum, then a good frame is accepted
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        send(q, 0);
        idle(2, 0);
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        send(q, 0);
        idle(1, 1);

        // Bad length, trailing byte ignored in IDLE
        q = '{8'hA5, 8'h10, 8'h11, 8'h10};
        send(q, 0);
        idle(2, 0);

        // Timeout after silence, and a strobe on the expiry cycle that suppresses it
        q = '{8'hA5, 8'h10};
        send(q, 0);
        idle(TOUT + 2, 0);
        send(q, 0);
        idle(TOUT - 1, 0);
        q = '{8'h00, 8'h10};
        send(q, 0);
        idle(1, 1);

        // Backpressure with overrun, then handshake and overrun in the same cycle
        q = '{8'hA5, 8'h42, 8'h03, 8'hA5, 8'h5A, 8'hC3, 8'h42 ^ 8'h03 ^ 8'hA5 ^ 8'h5A ^ 8'hC3};
        send(q, 0);
        idle(50, 0);
        step(1, 8'h77, 0);
        idle(3, 0);
        step(1, 8'hA5, 1);
        idle(2, 0);

        // Asynchronous reset mid-payload
        q = '{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02};
        send(q, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_in_frame = 0; m_holding = 0; m_silence = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 0);

        // Randomized streams: garbage, over-length, corrupted checksums, long gaps, random ready
        for (int f = 0; f < 60; f++) begin
            q.delete();
            if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom_range(0, 255)));
            q.push_back(8'hA5);
            q.push_back(8'($urandom_range(0, 255)));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_LEN + 1, MAX_LEN + 4)
                                               : $urandom_range(0, MAX_LEN);
            q.push_back(8'(len));
            x = q[q.size() - 2] ^ 8'(len);
            for (int i = 0; i < len; i++) begin
                q.push_back(8'($urandom_range(0, 255)));
                x ^= q[q.size() - 1];
            end
            if ($urandom_range(0, 4) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            q.push_back(x);
            foreach (q[i]) begin
                step(1, q[i], $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 39) == 0) idle($urandom_range(TOUT - 5, TOUT + 5), 0);
                else idle($urandom_range(0, 3), $urandom_range(0, 3) == 0);
            end
            idle($urandom_range(0, 4), $urandom_range(0, 1) == 1);
        end
        idle(4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
